// File: rtl/perf_latency_monitor_if.sv
// perf_latency_monitor_if
//
// Bundles the observed per-channel handshakes together with the statistics
// control and readout signals of perf_latency_monitor.
//
// Signals:
//   req      [NCH]    per-channel request strobe (observed)
//   data_ok  [NCH]    per-channel completion strobe (observed)
//   enable            statistics gate
//   clear             synchronous clear of all statistics
//   rd_ch    [CH_W]   readout channel select
//   rd_sel   [2]      readout field: 0 total, 1 hit, 2 lat_sum, 3 lat_max
//   rd_data  [CNT_W]  registered readout value
//   busy     [NCH]    channel has an outstanding transaction
//
// Modports:
//   master  drives stimulus/control, observes rd_data and busy
//   slave   the monitor itself
interface perf_latency_monitor_if #(
    parameter int NCH   = 2,
    parameter int CNT_W = 32,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   data_ok;
    logic             enable;
    logic             clear;
    logic [CH_W-1:0]  rd_ch;
    logic [1:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic [NCH-1:0]   busy;

    modport master (
        output req, data_ok, enable, clear, rd_ch, rd_sel,
        input  rd_data, busy
    );

    modport slave (
        input  req, data_ok, enable, clear, rd_ch, rd_sel,
        output rd_data, busy
    );
endinterface

// File: rtl/perf_latency_monitor.sv
// perf_latency_monitor
//
// Passive multi-channel request-latency profiler. Each channel follows one
// req/data_ok handshake, measures the latency of every completed transaction
// and keeps saturating total, hit, latency-sum and latency-max statistics.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   perf_latency_monitor_if.slave (req, data_ok, enable, clear,
//         rd_ch, rd_sel in; rd_data, busy out)
module perf_latency_monitor #(
    parameter int NCH       = 2,
    parameter int CNT_W     = 32,
    parameter int LAT_W     = 8,
    parameter int HIT_LIMIT = 3,
    parameter int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input logic clk,
    input logic rst,
    perf_latency_monitor_if.slave bus
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t           state   [NCH];
    logic [LAT_W-1:0] lat     [NCH];
    logic             counted [NCH];
    logic [CNT_W-1:0] total   [NCH];
    logic [CNT_W-1:0] hit     [NCH];
    logic [CNT_W-1:0] lat_sum [NCH];
    logic [LAT_W-1:0] lat_max [NCH];

    logic [LAT_W-1:0] lat_end [NCH];
    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] rd_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
        return (a == '1) ? a : a + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [LAT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Latency reported at completion: the WAIT cycles counted so far plus the
    // completion cycle itself, held at the counter's ceiling.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            lat_end[c] = (lat[c] == '1) ? lat[c] : lat[c] + 1'b1;
        end
    end

    // Readout mux; a channel index beyond NCH matches nothing and reads 0.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NCH; c++) begin
            if (int'(bus.rd_ch) == c) begin
                case (bus.rd_sel)
                    2'd0:    rd_mux = total[c];
                    2'd1:    rd_mux = hit[c];
                    2'd2:    rd_mux = lat_sum[c];
                    default: rd_mux = CNT_W'(lat_max[c]);
                endcase
            end
        end
    end

    // Per-channel FSM and statistics. The clear block sits last so that it
    // overrides every same-cycle update, including a fresh acceptance; it
    // also drops 'counted' so an in-flight transaction cannot add a hit
    // without its matching total.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            for (int c = 0; c < NCH; c++) begin
                state[c]   <= IDLE;
                lat[c]     <= '0;
                counted[c] <= 1'b0;
                total[c]   <= '0;
                hit[c]     <= '0;
                lat_sum[c] <= '0;
                lat_max[c] <= '0;
            end
        end else begin
            rd_data <= rd_mux;
            for (int c = 0; c < NCH; c++) begin
                case (state[c])
                    IDLE: begin
                        if (bus.req[c]) begin
                            if (bus.data_ok[c]) begin
                                // Zero-latency: always a hit, adds nothing to sum or max.
                                if (bus.enable) begin
                                    total[c] <= sat_inc(total[c]);
                                    hit[c]   <= sat_inc(hit[c]);
                                end
                            end else begin
                                state[c]   <= WAIT;
                                lat[c]     <= '0;
                                counted[c] <= bus.enable;
                                if (bus.enable) begin
                                    total[c] <= sat_inc(total[c]);
                                end
                            end
                        end
                    end
                    WAIT: begin
                        if (bus.data_ok[c]) begin
                            state[c] <= IDLE;
                            if (counted[c]) begin
                                lat_sum[c] <= sat_add(lat_sum[c], lat_end[c]);
                                if (int'(lat_end[c]) <= HIT_LIMIT) begin
                                    hit[c] <= sat_inc(hit[c]);
                                end
                                if (lat_end[c] > lat_max[c]) begin
                                    lat_max[c] <= lat_end[c];
                                end
                            end
                        end else if (lat[c] != '1) begin
                            lat[c] <= lat[c] + 1'b1;
                        end
                    end
                    default: state[c] <= IDLE;
                endcase

                if (bus.clear) begin
                    counted[c] <= 1'b0;
                    total[c]   <= '0;
                    hit[c]     <= '0;
                    lat_sum[c] <= '0;
                    lat_max[c] <= '0;
                end
            end
        end
    end

    assign bus.rd_data = rd_data;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            bus.busy[c] = (state[c] == WAIT);
        end
    end

endmodule

// File: tb/tb_perf_latency_monitor.sv
// tb_perf_latency_monitor
//
// Drives random handshakes, enable/clear/reset activity and readout selects
// into perf_latency_monitor, and compares rd_data and busy each cycle with a
// reference model that timestamps every request and derives latency from the
// cycle difference.
module tb_perf_latency_monitor;

    localparam int NCH       = 3;
    localparam int CNT_W     = 5;
    localparam int LAT_W     = 4;
    localparam int HIT_LIMIT = 3;
    localparam int CH_W      = 2;
    localparam longint CMAX  = (longint'(1) << CNT_W) - 1;
    localparam longint LMAX  = (longint'(1) << LAT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    perf_latency_monitor_if #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

    perf_latency_monitor #(
        .NCH(NCH), .CNT_W(CNT_W), .LAT_W(LAT_W),
        .HIT_LIMIT(HIT_LIMIT), .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit     m_busy  [NCH];
    bit     m_cnt   [NCH];
    int     req_cyc [NCH];
    longint m_total [NCH];
    longint m_hit   [NCH];
    longint m_sum   [NCH];
    longint m_max   [NCH];
    int     cyc = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, actual, expected);
        end
    endtask

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    // Account a finished transaction of latency l on channel c.
    function automatic void complete(input int c, input longint l);
        m_sum[c] = sat(m_sum[c] + l, CMAX);
        if (l <= HIT_LIMIT) m_hit[c] = sat(m_hit[c] + 1, CMAX);
        if (l > m_max[c]) m_max[c] = l;
    endfunction

    // One clock cycle: drive inputs, advance the model, check outputs.
    task automatic applyStimulus(input logic [NCH-1:0] r, input logic [NCH-1:0] ok,
                                 input logic en, input logic clr,
                                 input logic [CH_W-1:0] ch, input logic [1:0] sel,
                                 input logic rs);
        longint exp_rd;
        logic [NCH-1:0] exp_busy;
        int chi;
        @(negedge clk);
        bus.req = r;
        bus.data_ok = ok;
        bus.enable = en;
        bus.clear = clr;
        bus.rd_ch = ch;
        bus.rd_sel = sel;
        rst = rs;
        @(posedge clk);
        exp_rd = 0;
        if (rs) begin
            for (int c = 0; c < NCH; c++) begin
                m_busy[c] = 0; m_cnt[c] = 0;
                m_total[c] = 0; m_hit[c] = 0; m_sum[c] = 0; m_max[c] = 0;
            end
        end else begin
            chi = int'(ch);
            if (chi < NCH) begin
                case (sel)
                    2'd0: exp_rd = m_total[chi];
                    2'd1: exp_rd = m_hit[chi];
                    2'd2: exp_rd = m_sum[chi];
                    default: exp_rd = m_max[chi];
                endcase
            end
            for (int c = 0; c < NCH; c++) begin
                if (!m_busy[c]) begin
                    if (r[c]) begin
                        if (en) m_total[c] = sat(m_total[c] + 1, CMAX);
                        if (ok[c]) begin
                            if (en) complete(c, 0);
                        end else begin
                            m_busy[c] = 1;
                            req_cyc[c] = cyc;
                            m_cnt[c] = en;
                        end
                    end
                end else if (ok[c]) begin
                    m_busy[c] = 0;
                    if (m_cnt[c]) complete(c, sat(longint'(cyc - req_cyc[c]), LMAX));
                end
                if (clr) begin
                    m_cnt[c] = 0;
                    m_total[c] = 0; m_hit[c] = 0; m_sum[c] = 0; m_max[c] = 0;
                end
            end
        end
        cyc++;
        #1;
        for (int c = 0; c < NCH; c++) exp_busy[c] = m_busy[c];
        checkOutput("rd_data", 64'(bus.rd_data), 64'(exp_rd));
        checkOutput("busy", 64'(bus.busy), 64'(exp_busy));
    endtask

    initial begin
        logic [NCH-1:0] r, ok;
        int pr, pok, pen, pclr, prst;

        rst = 1'b1;
        bus.req = '0;
        bus.data_ok = '0;
        bus.enable = 1'b0;
        bus.clear = 1'b0;
        bus.rd_ch = '0;
        bus.rd_sel = '0;

        // Reset state
        applyStimulus('0, '0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b0, 2'd1, 2'd3, 1'b1);

        // Two zero-latency transactions on ch0, then read every field
        applyStimulus(3'b001, 3'b001, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        applyStimulus(3'b001, 3'b001, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        for (int s = 0; s < 4; s++) applyStimulus('0, '0, 1'b1, 1'b0, 2'd0, 2'(s), 1'b0);
        applyStimulus('0, '0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);

        // ch1: L=3 then L=4
        applyStimulus(3'b010, '0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus('0, '0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
        applyStimulus('0, 3'b010, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
        applyStimulus(3'b010, '0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
        applyStimulus('0, 3'b010, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
        for (int s = 0; s < 4; s++) applyStimulus('0, '0, 1'b1, 1'b0, 2'd1, 2'(s), 1'b0);
        applyStimulus('0, '0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);

        // Long wait on ch2 saturates L at 2^LAT_W-1
        applyStimulus(3'b100, '0, 1'b1, 1'b0, 2'd2, 2'd3, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus('0, '0, 1'b1, 1'b0, 2'd2, 2'd3, 1'b0);
        applyStimulus('0, 3'b100, 1'b1, 1'b0, 2'd2, 2'd3, 1'b0);
        applyStimulus('0, '0, 1'b1, 1'b0, 2'd2, 2'd3, 1'b0);

        // Random phases: dense traffic, long latencies, enable churn, resets
        for (int ph = 0; ph < 4; ph++) begin
            pr   = (ph == 1) ? 20 : 50;
            pok  = (ph == 0) ? 60 : ((ph == 1) ? 4 : 40);
            pen  = (ph == 2) ? 50 : 90;
            pclr = (ph == 2) ? 5 : 1;
            prst = (ph == 3) ? 1 : 0;
            for (int i = 0; i < 1500; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    r[c]  = ($urandom_range(0, 99) < pr);
                    ok[c] = ($urandom_range(0, 99) < pok);
                end
                applyStimulus(r, ok,
                              1'($urandom_range(0, 99) < pen),
                              1'($urandom_range(0, 99) < pclr),
                              2'($urandom_range(0, 3)),
                              2'($urandom_range(0, 3)),
                              1'($urandom_range(0, 99) < prst));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perf_latency_monitor.md
# perf_latency_monitor

Multi-channel request-latency profiler for the CPU–cache interface, used for performance analysis of the SoC. Each channel watches one req/data_ok handshake pair, for example I-cache, D-cache or uncached. For each completed transaction it measures latency and classifies it as a hit or miss against a threshold. It accumulates per-channel total, hit, latency-sum and latency-max statistics, with enable/clear control and a registered readout port. It is passive: it never drives the bus it observes.

## Interface
Parameters:
- NCH, 2: number of monitored channels (1..16).
- CNT_W, 32: width of total/hit/lat_sum counters.
- LAT_W, 8: width of the per-transaction latency counter and of lat_max.
- HIT_LIMIT, 3: a transaction with latency L ≤ HIT_LIMIT counts as a hit.
- CH_W, max(1, clog2(NCH)): width of rd_ch (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NCH  per-channel request strobe.
- data_ok  in  NCH  per-channel completion strobe.
- enable  in  1  statistics gate; 0 = FSMs keep tracking, no new transactions counted.
- clear  in  1  synchronous clear of all statistics.
- rd_ch  in  CH_W  readout channel select.
- rd_sel  in  2  readout field: 0 total, 1 hit, 2 lat_sum, 3 lat_max (zero-extended).
- rd_data  out  CNT_W  registered readout value.
- busy  out  NCH  channel has an outstanding transaction (FSM in WAIT).

## Operation
- Per channel: a 2-state FSM (IDLE, WAIT), a latency counter lat[LAT_W], a counted flag, and counters total, hit, lat_sum, lat_max.
- IDLE with req & data_ok: zero-latency transaction, L=0. Stays in IDLE. Counts as a hit.
- IDLE with req only: go to WAIT, lat←0, counted←enable.
- WAIT with data_ok low: lat←lat+1, saturating at 2^LAT_W−1.
- WAIT with data_ok high: go to IDLE with L=lat+1, saturated to 2^LAT_W−1.
- req while in WAIT is ignored. Only one outstanding transaction per channel.
- data_ok while IDLE without req is ignored.
- Accounting, each item only if the transaction is counted:
  - total+1 at acceptance, i.e. the req cycle in IDLE, gated by enable that cycle.
  - At completion: lat_sum += L (zero-extended), hit+1 if L ≤ HIT_LIMIT, lat_max ← max(lat_max, L).
  - For a zero-latency transaction, all updates occur in the same cycle, gated by enable.
- All CNT_W counters saturate at 2^CNT_W−1 and never wrap.
- clear:
  - Zeroes total, hit, lat_sum and lat_max of all channels.
  - Drops the counted flag of every outstanding transaction, so hit ≤ total always holds.
  - Does not change FSM state or lat.
  - Takes priority over any same-cycle update, including a same-cycle acceptance.
- enable=0 mid-transaction: a transaction already counted still completes its accounting.
- Readout: rd_data ← field rd_sel of channel rd_ch each cycle; rd_ch ≥ NCH yields 0.
- Channels are fully independent. Simultaneous events on different channels all update in the same cycle.

## Timing
- Reset: all FSMs IDLE, lat=0, counted=0, all counters 0, rd_data=0, busy=0.
- rst overrides clear and enable, and aborts outstanding transactions without accounting.
- busy rises the edge after the req cycle and falls the edge after the data_ok cycle.
- Counter updates take effect at the clock edge ending the acceptance or completion cycle.
- rd_data latency is 1 cycle. It shows register values as they were before the same edge's update.
- L counts cycles from the req cycle to the data_ok cycle: data_ok in the cycle right after req gives L=1.

## Test plan
- Ch0: req&data_ok same cycle ×2, then read rd_sel 0..3 → total=2, hit=2, lat_sum=0, lat_max=0.
- Ch1: req, data_ok 3 cycles later (L=3), then req, data_ok 4 cycles later (L=4), HIT_LIMIT=3 → total=2, hit=1, lat_sum=7, lat_max=4; busy[1] high exactly L cycles each time.
- Overlap: ch0 and ch1 complete in the same cycle, and a second req on ch0 arrives while in WAIT → both channels update; the extra req is ignored, so total increments by one.
- enable=0 at acceptance, enable=1 at completion → no counter change. Accepted with enable=1, enable dropped before completion → full accounting.
- clear asserted while ch0 is in WAIT, then data_ok → all counters 0 after completion, busy[0] falls normally. clear and acceptance in the same cycle → total=0.
- LAT_W=4, data_ok after 20 cycles → L=15, lat_max=15. CNT_W=4 with 17 transactions → total stays 15. rd_ch=NCH → rd_data=0. rst mid-WAIT → all outputs 0 the next cycle.
